// File: rtl/ram_store_buffer_if.sv
// Store-buffer bus: CPU store/load/flush requests in, RAM write port and status out.
// master = CPU side, slave = ram_store_buffer.
interface ram_store_buffer_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              flush;
    logic              flush_done;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, flush,
        input  st_ready, ld_hit, ld_data, flush_done, ram_wren, ram_address,
               ram_data, count, empty, full
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, flush,
        output st_ready, ld_hit, ld_data, flush_done, ram_wren, ram_address,
               ram_data, count, empty, full
    );
endinterface

// File: rtl/ram_store_buffer.sv
// Posted-write FIFO between the CPU store path and RAM32x1024 with load forwarding.
// Optional STORE_COALESCE_EN merges a store into the youngest entry when addresses match.
module ram_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic             MAX10_CLK1_50,
    input  logic             reset,
    ram_store_buffer_if.slave io_bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ram_wren;
    logic [ADDR_W-1:0] r_ram_address;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_flush_done;

    logic              w_full;
    logic              w_empty;
    logic              w_flushing;
    logic              w_pop;
    logic              w_push;
    logic              w_coal;
    logic              w_st_ready;
    logic [PTR_W-1:0]  w_young_idx;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [PTR_W-1:0]  w_fwd_idx;
    logic              w_ld_hit;
    logic [DATA_W-1:0] w_ld_data;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_flushing  = (r_state == S_FLUSH);
    assign w_pop       = ~w_empty & ~io_bus.ld_valid;
    assign w_young_idx = r_wr_ptr - PTR_W'(1);

`ifdef STORE_COALESCE_EN
    // Merge only if the youngest entry survives this edge (not the lone entry being popped).
    assign w_coal     = io_bus.st_valid & ~w_flushing & ~w_empty
                      & (r_mem_addr[w_young_idx] == io_bus.st_addr)
                      & ~(w_pop & (r_count == CNT_W'(1)));
    assign w_st_ready = (~w_full | w_coal) & ~w_flushing;
`else
    assign w_coal     = 1'b0;
    assign w_st_ready = ~w_full & ~w_flushing;
`endif

    assign w_push     = io_bus.st_valid & w_st_ready & ~w_coal;
    assign w_cnt_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        w_ld_hit  = 1'b0;
        w_ld_data = '0;
        w_fwd_idx = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_fwd_idx = r_rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_mem_addr[w_fwd_idx] == io_bus.ld_addr)) begin
                w_ld_hit  = 1'b1;
                w_ld_data = r_mem_data[w_fwd_idx];
            end
        end
    end

    // Entry storage
    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem_addr[i] <= '0;
                r_mem_data[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_addr[r_wr_ptr] <= io_bus.st_addr;
            r_mem_data[r_wr_ptr] <= io_bus.st_data;
        end else if (w_coal) begin
            r_mem_data[w_young_idx] <= io_bus.st_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_cnt_next;
        end
    end

    // RAM write port: head entry registered out on the edge it pops
    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset) begin
            r_ram_wren    <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
        end else begin
            r_ram_wren <= w_pop;
            if (w_pop) begin
                r_ram_address <= r_mem_addr[r_rd_ptr];
                r_ram_data    <= r_mem_data[r_rd_ptr];
            end
        end
    end

    // Control FSM; FLUSH completion takes precedence over a still-held flush
    always_ff @(posedge MAX10_CLK1_50 or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.flush)  r_state <= S_FLUSH;
                    else if (w_push)   r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (io_bus.flush)            r_state <= S_FLUSH;
                    else if (w_cnt_next == '0)   r_state <= S_IDLE;
                end
                S_FLUSH: begin
                    if (w_empty) begin
                        r_state      <= S_IDLE;
                        r_flush_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.st_ready    = w_st_ready;
    assign io_bus.ld_hit      = w_ld_hit;
    assign io_bus.ld_data     = w_ld_data;
    assign io_bus.flush_done  = r_flush_done;
    assign io_bus.ram_wren    = r_ram_wren;
    assign io_bus.ram_address = r_ram_address;
    assign io_bus.ram_data    = r_ram_data;
    assign io_bus.count       = r_count;
    assign io_bus.empty       = w_empty;
    assign io_bus.full        = w_full;

endmodule

// File: tb/tb_ram_store_buffer.sv
// Directed table-driven bench for ram_store_buffer (DEPTH=4, ADDR_W=5, DATA_W=32),
// plus hand-written reset-state and async-reset-mid-drain sequences.
module tb_ram_store_buffer;
    logic clk;
    logic rst_n;
    int   n_err;
    int   n_checks;

    ram_store_buffer_if #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) bus ();

    ram_store_buffer #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
        .MAX10_CLK1_50 (clk),
        .reset         (rst_n),
        .io_bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st_v;
        logic [4:0]  st_a;
        logic [31:0] st_d;
        logic        ld_v;
        logic [4:0]  ld_a;
        logic        fl;
        logic        e_rdy;   // before the edge
        logic        e_hit;
        logic [31:0] e_ldd;
        logic        e_wren;  // after the edge
        logic [4:0]  e_ra;
        logic [31:0] e_rd;
        logic [2:0]  e_cnt;
        logic        e_fd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st_v, input logic [4:0] st_a, input logic [31:0] st_d,
                                input logic ld_v, input logic [4:0] ld_a, input logic fl,
                                input logic e_rdy, input logic e_hit, input logic [31:0] e_ldd,
                                input logic e_wren, input logic [4:0] e_ra, input logic [31:0] e_rd,
                                input logic [2:0] e_cnt, input logic e_fd);
        vec_t v;
        v.st_v = st_v; v.st_a = st_a; v.st_d = st_d;
        v.ld_v = ld_v; v.ld_a = ld_a; v.fl = fl;
        v.e_rdy = e_rdy; v.e_hit = e_hit; v.e_ldd = e_ldd;
        v.e_wren = e_wren; v.e_ra = e_ra; v.e_rd = e_rd; v.e_cnt = e_cnt; v.e_fd = e_fd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st_v, input logic [4:0] st_a, input logic [31:0] st_d,
                         input logic ld_v, input logic [4:0] ld_a, input logic fl);
        bus.st_valid = st_v;
        bus.st_addr  = st_a;
        bus.st_data  = st_d;
        bus.ld_valid = ld_v;
        bus.ld_addr  = ld_a;
        bus.flush    = fl;
    endtask

    initial begin
        n_err    = 0;
        n_checks = 0;
        rst_n    = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);

        //      st_v st_a   st_d          ld_v ld_a   fl   rdy  hit  ldd           wren ra     rd            cnt   fd
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd0, 0));
        tbl.push_back(mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd1, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd5,  0,   1, 1, 32'hDEADBEEF, 1, 5'd5,  32'hDEADBEEF, 3'd0, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd5,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd0, 0));
        // fill with loads blocking drain, fifth store dropped
        tbl.push_back(mk(1, 5'd1,  32'hA1,       1, 5'd9,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd1, 0));
        tbl.push_back(mk(1, 5'd2,  32'hA2,       1, 5'd9,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd2, 0));
        tbl.push_back(mk(1, 5'd3,  32'hA3,       1, 5'd9,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd3, 0));
        tbl.push_back(mk(1, 5'd4,  32'hA4,       1, 5'd9,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd4, 0));
        tbl.push_back(mk(1, 5'd6,  32'hA6,       1, 5'd2,  0,   0, 1, 32'hA2,       0, 5'd0,  32'h0,        3'd4, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd9,  0,   0, 0, 32'h0,        1, 5'd1,  32'hA1,       3'd3, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd9,  0,   1, 0, 32'h0,        1, 5'd2,  32'hA2,       3'd2, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd9,  0,   1, 0, 32'h0,        1, 5'd3,  32'hA3,       3'd1, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd9,  0,   1, 0, 32'h0,        1, 5'd4,  32'hA4,       3'd0, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd6,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd0, 0));
        // forwarding of two stores to address 3
        tbl.push_back(mk(1, 5'd3,  32'h11,       1, 5'd3,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd1, 0));
`ifdef STORE_COALESCE_EN
        tbl.push_back(mk(1, 5'd3,  32'h22,       1, 5'd3,  0,   1, 1, 32'h11,       0, 5'd0,  32'h0,        3'd1, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        1, 5'd3,  0,   1, 1, 32'h22,       0, 5'd0,  32'h0,        3'd1, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd3,  0,   1, 1, 32'h22,       1, 5'd3,  32'h22,       3'd0, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd3,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd0, 0));
`else
        tbl.push_back(mk(1, 5'd3,  32'h22,       1, 5'd3,  0,   1, 1, 32'h11,       0, 5'd0,  32'h0,        3'd2, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        1, 5'd3,  0,   1, 1, 32'h22,       0, 5'd0,  32'h0,        3'd2, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd3,  0,   1, 1, 32'h22,       1, 5'd3,  32'h11,       3'd1, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd3,  0,   1, 1, 32'h22,       1, 5'd3,  32'h22,       3'd0, 0));
`endif
        // push and pop in the same cycle at count=2
        tbl.push_back(mk(1, 5'd7,  32'hB7,       1, 5'd0,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd1, 0));
        tbl.push_back(mk(1, 5'd8,  32'hB8,       1, 5'd0,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd2, 0));
        tbl.push_back(mk(1, 5'd9,  32'hB9,       0, 5'd0,  0,   1, 0, 32'h0,        1, 5'd7,  32'hB7,       3'd2, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  0,   1, 0, 32'h0,        1, 5'd8,  32'hB8,       3'd1, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  0,   1, 0, 32'h0,        1, 5'd9,  32'hB9,       3'd0, 0));
        // flush with three entries; store during FLUSH refused
        tbl.push_back(mk(1, 5'd10, 32'hC0,       1, 5'd0,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd1, 0));
        tbl.push_back(mk(1, 5'd11, 32'hC1,       1, 5'd0,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd2, 0));
        tbl.push_back(mk(1, 5'd12, 32'hC2,       1, 5'd0,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd3, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  1,   1, 0, 32'h0,        1, 5'd10, 32'hC0,       3'd2, 0));
        tbl.push_back(mk(1, 5'd13, 32'hDD,       0, 5'd13, 0,   0, 0, 32'h0,        1, 5'd11, 32'hC1,       3'd1, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  0,   0, 0, 32'h0,        1, 5'd12, 32'hC2,       3'd0, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  0,   0, 0, 32'h0,        0, 5'd0,  32'h0,        3'd0, 1));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd0, 0));
        // flush while already empty
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  1,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd0, 0));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  0,   0, 0, 32'h0,        0, 5'd0,  32'h0,        3'd0, 1));
        tbl.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  0,   1, 0, 32'h0,        0, 5'd0,  32'h0,        3'd0, 0));

        // reset state, checked while reset is still asserted
        #12;
        chk("rst_wren",    32'(bus.ram_wren),    32'd0);
        chk("rst_addr",    32'(bus.ram_address), 32'd0);
        chk("rst_data",    bus.ram_data,         32'd0);
        chk("rst_count",   32'(bus.count),       32'd0);
        chk("rst_empty",   32'(bus.empty),       32'd1);
        chk("rst_full",    32'(bus.full),        32'd0);
        chk("rst_ready",   32'(bus.st_ready),    32'd1);
        chk("rst_hit",     32'(bus.ld_hit),      32'd0);
        chk("rst_ldd",     bus.ld_data,          32'd0);
        chk("rst_fdone",   32'(bus.flush_done),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            drive(tbl[k].st_v, tbl[k].st_a, tbl[k].st_d, tbl[k].ld_v, tbl[k].ld_a, tbl[k].fl);
            #1;
            chk($sformatf("v%0d st_ready", k), 32'(bus.st_ready), 32'(tbl[k].e_rdy));
            chk($sformatf("v%0d ld_hit", k),   32'(bus.ld_hit),   32'(tbl[k].e_hit));
            chk($sformatf("v%0d ld_data", k),  bus.ld_data,       tbl[k].e_ldd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ram_wren", k), 32'(bus.ram_wren), 32'(tbl[k].e_wren));
            if (tbl[k].e_wren) begin
                chk($sformatf("v%0d ram_address", k), 32'(bus.ram_address), 32'(tbl[k].e_ra));
                chk($sformatf("v%0d ram_data", k),    bus.ram_data,         tbl[k].e_rd);
            end
            chk($sformatf("v%0d count", k),      32'(bus.count),      32'(tbl[k].e_cnt));
            chk($sformatf("v%0d empty", k),      32'(bus.empty),      32'(tbl[k].e_cnt == 3'd0));
            chk($sformatf("v%0d full", k),       32'(bus.full),       32'(tbl[k].e_cnt == 3'd4));
            chk($sformatf("v%0d flush_done", k), 32'(bus.flush_done), 32'(tbl[k].e_fd));
        end

        // asynchronous reset in the middle of a drain
        @(negedge clk);
        drive(1'b1, 5'd1, 32'hE1, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        drive(1'b1, 5'd2, 32'hE2, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd2, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_wren",  32'(bus.ram_wren),    32'd1);
        chk("mid_addr",  32'(bus.ram_address), 32'd1);
        chk("mid_count", 32'(bus.count),       32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wren",  32'(bus.ram_wren), 32'd0);
        chk("arst_count", 32'(bus.count),    32'd0);
        chk("arst_empty", 32'(bus.empty),    32'd1);
        chk("arst_hit",   32'(bus.ld_hit),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_wren",  32'(bus.ram_wren), 32'd0);
        chk("post_rst_count", 32'(bus.count),    32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
